// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the 7-segment scan controller:
//     SEG_BLANK      all segments off (active-low pattern)
//     GLYPH_0..F     active-low {g,f,e,d,c,b,a} codes for the 16 hex glyphs
//     slot_phase_e   BLANK/DRIVE phase of one digit slot
//     clog2_min1     bit width needed to hold 0..value-1, never less than 1
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } slot_phase_e;

    // A 1-digit display still needs a 1-bit index register, so the
    // width is clamped at 1 instead of collapsing to 0.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// ---------------------------------------------------------------------------
// seg_hex_decode
//   Combinational hex-digit to 7-segment glyph decoder, active-low outputs.
//   Ports:
//     nibble  in   4   hex value 0..F
//     seg_n   out  7   segments {g,f,e,d,c,b,a}, 0 = lit
// ---------------------------------------------------------------------------
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Plain lookup; every nibble value has a glyph, the default only keeps
    // the block free of any implied storage.
    always_comb begin
        seg_n = SEG_BLANK;
        case (nibble)
            4'h0: seg_n = GLYPH_0;
            4'h1: seg_n = GLYPH_1;
            4'h2: seg_n = GLYPH_2;
            4'h3: seg_n = GLYPH_3;
            4'h4: seg_n = GLYPH_4;
            4'h5: seg_n = GLYPH_5;
            4'h6: seg_n = GLYPH_6;
            4'h7: seg_n = GLYPH_7;
            4'h8: seg_n = GLYPH_8;
            4'h9: seg_n = GLYPH_9;
            4'hA: seg_n = GLYPH_A;
            4'hB: seg_n = GLYPH_B;
            4'hC: seg_n = GLYPH_C;
            4'hD: seg_n = GLYPH_D;
            4'hE: seg_n = GLYPH_E;
            4'hF: seg_n = GLYPH_F;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Scans NUM_DIGITS hex digits onto one common-anode 7-segment bank through
//   a single shared decoder. Each digit slot lasts PRESCALE clocks; the first
//   BLANK_CYC clocks of a slot keep every anode off to avoid ghosting. New
//   values are written into staging registers and copied into the displayed
//   (shadow) registers only at a frame boundary.
//   Ports:
//     clk          in   1             system clock, rising edge
//     rst_n        in   1             asynchronous active-low reset
//     wr_en        in   1             load wr_data/wr_dp/wr_mask into staging
//     wr_data      in   4*NUM_DIGITS  nibbles, digit 0 in bits [3:0]
//     wr_dp        in   NUM_DIGITS    decimal point per digit, 1 = lit
//     wr_mask      in   NUM_DIGITS    digit enable, 0 = forced blank
//     lzb_en       in   1             leading-zero blanking, applied live
//     seg_n        out  7             segments {g,f,e,d,c,b,a}, active-low
//     dp_n         out  1             decimal point, active-low
//     an_n         out  NUM_DIGITS    anode select, active-low
//     upd_pending  out  1             staged value not yet displayed
//     frame_done   out  1             one-clock pulse after the last slot
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic [NUM_DIGITS-1:0]   wr_mask,
    input  logic                    lzb_en,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    upd_pending,
    output logic                    frame_done
);

    localparam int PCNT_W = clog2_min1(PRESCALE);
    localparam int IDX_W  = clog2_min1(NUM_DIGITS);

    localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(PRESCALE - 1);
    localparam logic [PCNT_W-1:0] PCNT_BLANK = PCNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [PCNT_W-1:0] pcnt, pcnt_next;
    logic [IDX_W-1:0]  idx, idx_next;
    slot_phase_e       phase, phase_next;
    logic              slot_end, frame_end;

    // The mask is stored inverted ("digit off" bits) so that the cleared
    // reset state means every digit is enabled and the display shows 0000.
    logic [4*NUM_DIGITS-1:0] stage_data, shadow_data;
    logic [NUM_DIGITS-1:0]   stage_dp, shadow_dp;
    logic [NUM_DIGITS-1:0]   stage_off, shadow_off;

    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_off, cur_lzb, zero_run;
    logic [6:0]            glyph;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;

    assign slot_end  = (pcnt == PCNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Next prescaler/index values and the phase they imply. The phase is
    // registered alongside pcnt, so it always describes the current count.
    always_comb begin
        pcnt_next = pcnt + 1'b1;
        idx_next  = idx;
        if (slot_end) begin
            pcnt_next = '0;
            idx_next  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        phase_next = (pcnt_next < PCNT_BLANK) ? PH_BLANK : PH_DRIVE;
    end

    // Scan state register: prescaler, digit index and slot phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt  <= '0;
            idx   <= '0;
            phase <= PH_BLANK;
        end else begin
            pcnt  <= pcnt_next;
            idx   <= idx_next;
            phase <= phase_next;
        end
    end

    // Double buffer. Shadow takes the staging contents as they were before
    // this edge, so a write landing on the boundary edge waits one frame and
    // keeps upd_pending set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_data  <= '0;
            stage_dp    <= '0;
            stage_off   <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            shadow_off  <= '0;
            upd_pending <= 1'b0;
        end else begin
            if (frame_end) begin
                shadow_data <= stage_data;
                shadow_dp   <= stage_dp;
                shadow_off  <= stage_off;
            end
            if (wr_en) begin
                stage_data <= wr_data;
                stage_dp   <= wr_dp;
                stage_off  <= ~wr_mask;
            end
            if (wr_en) begin
                upd_pending <= 1'b1;
            end else if (frame_end) begin
                upd_pending <= 1'b0;
            end
        end
    end

    // Select the shadow digit for the current slot. zero_run walks down from
    // the most significant digit, so at digit i it says whether nibbles
    // i..NUM_DIGITS-1 are all zero; digit 0 is never zero-blanked.
    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_off  = 1'b0;
        cur_lzb  = 1'b0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (shadow_data[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                cur_nib = shadow_data[4*i +: 4];
                cur_dp  = shadow_dp[i];
                cur_off = shadow_off[i];
                cur_lzb = lzb_en && (i != 0) && zero_run;
            end
        end
    end

    seg_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .seg_n  (glyph)
    );

    // Pin values for the current slot. A masked digit loses both glyph and
    // decimal point; a zero-blanked digit keeps its decimal point. The anode
    // strobes in either case.
    always_comb begin
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        an_next  = '1;
        if (phase == PH_DRIVE) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx == IDX_W'(i)) an_next[i] = 1'b0;
            end
            if (!cur_off) begin
                dp_next = ~cur_dp;
                if (!cur_lzb) seg_next = glyph;
            end
        end
    end

    // Output registers: pins trail the scan state by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= seg_next;
            dp_n       <= dp_next;
            an_n       <= an_next;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Bench for seg_scan_ctrl with NUM_DIGITS=4, PRESCALE=8, BLANK_CYC=2.
//   A cycle-count model predicts the pins every clock; directed scenarios
//   pin literal glyph values, then randomized writes run against the model.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = N * P;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wr_en   = 1'b0;
    logic        lzb_en  = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_dp   = '0;
    logic [3:0]  wr_mask = '0;

    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic       upd_pending;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS (N),
        .PRESCALE   (P),
        .BLANK_CYC  (B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .wr_mask     (wr_mask),
        .lzb_en      (lzb_en),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .upd_pending (upd_pending),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Standard hex glyphs, active-low {g,f,e,d,c,b,a}.
    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // What the pins must show for a given slot position and displayed value.
    function automatic void model_pins(input int pc, input int ix, input logic [15:0] d,
                                       input logic [3:0] dpv, input logic [3:0] msk, input logic lz,
                                       output logic [6:0] s, output logic p, output logic [3:0] a);
        logic [3:0] nib;
        s = 7'h7F;
        p = 1'b1;
        a = 4'hF;
        if (pc >= B) begin
            a   = 4'hF & ~(4'd1 << ix);
            nib = d[4*ix +: 4];
            if (msk[ix]) begin
                p = ~dpv[ix];
                if (!(lz && ix > 0 && (d >> (4*ix)) == 16'd0)) s = glyph_tab[nib];
            end
        end
    endfunction

    // Model state: m_cyc counts clocks since reset release; after each edge
    // the pins describe clock number shown_cyc = m_cyc-1.
    int         m_cyc;
    int         shown_cyc = -1;
    logic [15:0] m_stage_d, m_shad_d;
    logic [3:0]  m_stage_dp, m_shad_dp, m_stage_mask, m_shad_mask;
    logic        m_pend;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd, e_pend;
    logic [3:0]  e_an;
    bit          e_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc        = 0;
            m_stage_d    = '0;
            m_stage_dp   = '0;
            m_stage_mask = 4'hF;
            m_shad_d     = '0;
            m_shad_dp    = '0;
            m_shad_mask  = 4'hF;
            m_pend       = 1'b0;
            e_seg        = 7'h7F;
            e_dp         = 1'b1;
            e_an         = 4'hF;
            e_fd         = 1'b0;
            e_pend       = 1'b0;
            shown_cyc    = -1;
            e_valid      = 1'b1;
        end else begin
            model_pins(m_cyc % P, (m_cyc / P) % N, m_shad_d, m_shad_dp, m_shad_mask, lzb_en,
                       e_seg, e_dp, e_an);
            e_fd = ((m_cyc % FRAME) == FRAME - 1);
            if (e_fd) begin
                m_shad_d    = m_stage_d;
                m_shad_dp   = m_stage_dp;
                m_shad_mask = m_stage_mask;
            end
            if (wr_en) begin
                m_stage_d    = wr_data;
                m_stage_dp   = wr_dp;
                m_stage_mask = wr_mask;
                m_pend       = 1'b1;
            end else if (e_fd) begin
                m_pend = 1'b0;
            end
            e_pend    = m_pend;
            shown_cyc = m_cyc;
            m_cyc++;
        end
    end

    // Every-clock comparison against the model, plus anode sanity and the
    // blank-gap length between consecutive drive phases.
    int         blank_run = 0;
    bit         run_ok    = 1'b0;
    logic [3:0] prev_an   = 4'hF;

    always @(negedge clk) begin
        if (e_valid) begin
            checkOutput("seg_n", 16'(seg_n), 16'(e_seg));
            checkOutput("dp_n", 16'(dp_n), 16'(e_dp));
            checkOutput("an_n", 16'(an_n), 16'(e_an));
            checkOutput("upd_pending", 16'(upd_pending), 16'(e_pend));
            checkOutput("frame_done", 16'(frame_done), 16'(e_fd));
            if (rst_n) begin
                checkOutput("an_onehot", 16'($countones(~an_n) <= 1), 16'd1);
                if (an_n == 4'hF) begin
                    blank_run++;
                end else begin
                    if (prev_an == 4'hF) begin
                        if (run_ok) checkOutput("blank_len", 16'(blank_run), 16'(B));
                        run_ok = 1'b1;
                    end else if (prev_an != an_n) begin
                        checkOutput("blank_len", 16'd0, 16'(B));
                    end
                    blank_run = 0;
                end
                prev_an = an_n;
            end else begin
                run_ok    = 1'b0;
                blank_run = 0;
                prev_an   = 4'hF;
            end
        end
    end

    // Wait (at negedges) until the pins show slot ix at prescaler value pc.
    task automatic waitShown(input int ix, input int pc);
        int  n;
        bit  hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            @(negedge clk);
            n++;
            hit = (shown_cyc >= 0) && (shown_cyc % P == pc) && ((shown_cyc / P) % N == ix);
        end
        if (!hit) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_slot: no slot %0d pcnt %0d within %0d clocks", ix, pc, n);
        end
    endtask

    // Called at a negedge; wr_en is high for exactly the next rising edge.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] msk);
        wr_data = d;
        wr_dp   = dpv;
        wr_mask = msk;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic checkDigit(input string name, input int ix, input logic [6:0] s, input logic p);
        waitShown(ix, B);
        checkOutput({name, "_seg"}, 16'(seg_n), 16'(s));
        checkOutput({name, "_dp"}, 16'(dp_n), 16'(p));
        checkOutput({name, "_an"}, 16'(an_n), 16'(4'hF & ~(4'd1 << ix)));
    endtask

    initial begin
        #500000;
        total++;
        bad++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int          n;
        logic [15:0] rd;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_seg", 16'(seg_n), 16'h7F);
        checkOutput("rst_an", 16'(an_n), 16'hF);
        checkOutput("rst_pend", 16'(upd_pending), 16'd0);
        rst_n = 1'b1;

        // Scan with no writes: every digit shows 0, anodes E,D,B,7
        $display("[TB] scan after reset");
        checkDigit("t1_d0", 0, 7'h40, 1'b1);
        checkDigit("t1_d1", 1, 7'h40, 1'b1);
        checkDigit("t1_d2", 2, 7'h40, 1'b1);
        checkDigit("t1_d3", 3, 7'h40, 1'b1);
        waitShown(3, P - 1);
        checkOutput("t1_fd_at_end", 16'(frame_done), 16'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_done && n < 100);
        checkOutput("t1_fd_period", 16'(n), 16'(FRAME));

        // Mid-frame write, shown from next frame
        $display("[TB] mid-frame write");
        waitShown(1, 3);
        applyStimulus(16'h12AF, 4'b0001, 4'hF);
        checkOutput("t2_pend_set", 16'(upd_pending), 16'd1);
        waitShown(3, P - 2);
        checkOutput("t2_pend_hold", 16'(upd_pending), 16'd1);
        waitShown(3, P - 1);
        checkOutput("t2_pend_clr", 16'(upd_pending), 16'd0);
        checkDigit("t2_d0", 0, 7'h0E, 1'b0);
        checkDigit("t2_d1", 1, 7'h08, 1'b1);
        checkDigit("t2_d2", 2, 7'h24, 1'b1);
        checkDigit("t2_d3", 3, 7'h79, 1'b1);

        // Leading-zero blanking, dp on a zero-blanked digit stays lit
        $display("[TB] leading-zero blanking");
        lzb_en = 1'b1;
        waitShown(1, 4);
        applyStimulus(16'h0050, 4'b1000, 4'hF);
        checkDigit("t3_d0", 0, 7'h40, 1'b1);
        checkDigit("t3_d1", 1, 7'h12, 1'b1);
        checkDigit("t3_d2", 2, 7'h7F, 1'b1);
        checkDigit("t3_d3", 3, 7'h7F, 1'b0);
        lzb_en = 1'b0;
        checkDigit("t3_d2_nolzb", 2, 7'h40, 1'b1);
        checkDigit("t3_d3_nolzb", 3, 7'h40, 1'b0);

        // Last write wins; a write on the boundary edge waits a frame
        $display("[TB] write on frame boundary");
        waitShown(0, 4);
        applyStimulus(16'h1111, 4'b0000, 4'hF);
        waitShown(1, 4);
        applyStimulus(16'h2222, 4'b0000, 4'hF);
        waitShown(3, P - 2);
        applyStimulus(16'h3333, 4'b0000, 4'hF);
        checkOutput("t4_fd", 16'(frame_done), 16'd1);
        checkOutput("t4_pend_kept", 16'(upd_pending), 16'd1);
        checkDigit("t4_d0_2", 0, 7'h24, 1'b1);
        checkOutput("t4_pend_still", 16'(upd_pending), 16'd1);
        checkDigit("t4_d3_2", 3, 7'h24, 1'b1);
        checkDigit("t4_d0_3", 0, 7'h30, 1'b1);
        checkOutput("t4_pend_done", 16'(upd_pending), 16'd0);

        // Mask 0101: digits 1 and 3 blank (no dp) while anodes still strobe
        $display("[TB] digit mask");
        waitShown(1, 4);
        applyStimulus(16'h4321, 4'hF, 4'b0101);
        checkDigit("t6_d0", 0, 7'h79, 1'b0);
        checkDigit("t6_d1", 1, 7'h7F, 1'b1);
        checkDigit("t6_d2", 2, 7'h30, 1'b0);
        checkDigit("t6_d3", 3, 7'h7F, 1'b1);

        // Asynchronous reset at pcnt 5 of slot 2 with a write pending
        $display("[TB] reset mid-frame");
        waitShown(1, 4);
        applyStimulus(16'h9999, 4'hF, 4'hF);
        waitShown(2, 4);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_seg", 16'(seg_n), 16'h7F);
        checkOutput("t5_dp", 16'(dp_n), 16'd1);
        checkOutput("t5_an", 16'(an_n), 16'hF);
        checkOutput("t5_pend", 16'(upd_pending), 16'd0);
        checkOutput("t5_fd", 16'(frame_done), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (an_n == 4'hF && n < 50);
        checkOutput("t5_restart_lat", 16'(n), 16'(B + 1));
        checkOutput("t5_restart_an", 16'(an_n), 16'hE);
        checkOutput("t5_restart_seg", 16'(seg_n), 16'h40);
        checkDigit("t5_d2", 2, 7'h40, 1'b1);

        // Randomized writes and lzb toggling, checked by the model
        $display("[TB] random traffic");
        repeat (60) begin
            repeat ($urandom_range(1, 24)) @(negedge clk);
            lzb_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                rd = 16'($urandom);
                rd = rd >> (4 * $urandom_range(0, 3));
                applyStimulus(rd, 4'($urandom), 4'($urandom_range(0, 15) | ($urandom_range(0, 1) ? 15 : 0)));
            end
        end
        repeat (2 * FRAME) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
